// File: rtl/alu_mc.sv
// alu_mc: registered EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/logic/compare/shift) produce a result one cycle
// after accept. MUL/MULHU run an iterative shift-add multiplier that retires
// MUL_STEP multiplier bits per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operands/opcode valid          in_ready  block can take an op
//   A, B       operands (B[log2(WIDTH)-1:0] is the shift amount)
//   ALUcontrol 4-bit opcode
//   out_valid  Result/flags valid             out_ready consumer takes result
//   Result     registered result
//   Z, V, N, C zero, signed overflow, negative, carry (V/C only for ADD/SUB)
//   busy       multiplier iterating
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             C,
    output logic             busy
);

    localparam int SH_W   = $clog2(WIDTH);
    localparam int N_STEP = WIDTH / MUL_STEP;
    localparam int CNT_W  = $clog2(N_STEP + 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t state, state_nxt;

    // Z and N always follow the final result, whichever path produced it.
    function automatic logic [1:0] zn_flags(input logic [WIDTH-1:0] r);
        return {(r == '0), r[WIDTH-1]};
    endfunction

    logic xfer;
    logic is_mul;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign xfer      = in_valid && in_ready;
    assign is_mul    = (ALUcontrol == OP_MUL) || (ALUcontrol == OP_MULHU);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL);

    // ---- Stage p0: single-cycle datapath on the incoming operands ----
    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    sub, is_arith;
    logic        [WIDTH-1:0] b_op, sum, alu_res;
    logic        [WIDTH:0]   add_full;
    logic        [SH_W-1:0]  shamt;
    logic                    alu_v, alu_c;

    assign a_s   = A;
    assign b_s   = B;
    assign shamt = B[SH_W-1:0];

    always_comb begin
        sub      = (ALUcontrol == OP_SUB);
        is_arith = (ALUcontrol == OP_ADD) || sub;
        b_op     = sub ? ~B : B;
        add_full = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
        sum      = add_full[WIDTH-1:0];
        alu_c    = is_arith && add_full[WIDTH];
        alu_v    = is_arith && (~(A[WIDTH-1] ^ B[WIDTH-1] ^ sub) & (A[WIDTH-1] ^ sum[WIDTH-1]));
        alu_res  = '0;
        case (ALUcontrol)
            OP_ADD, OP_SUB: alu_res = sum;
            OP_AND:         alu_res = A & B;
            OP_OR:          alu_res = A | B;
            OP_XOR:         alu_res = A ^ B;
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:         alu_res = A << shamt;
            OP_SRL:         alu_res = A >> shamt;
            OP_SRA:         alu_res = a_s >>> shamt;
            default:        alu_res = '0;  // MUL handled iteratively; reserved codes give 0
        endcase
    end

    // ---- Stage p1: iterative shift-add multiplier ----
    logic [2*WIDTH-1:0] acc_p1, mcand_p1, pp, acc_next;
    logic [WIDTH-1:0]   mplier_p1, mul_res;
    logic [CNT_W-1:0]   cnt_p1;
    logic               mul_hi_p1;

    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_p1[j]) pp = pp + (mcand_p1 << j);
        end
        acc_next = acc_p1 + pp;
        mul_res  = mul_hi_p1 ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        if (xfer)
            state_nxt = is_mul ? S_MUL : S_DONE;
        else if (state == S_MUL && cnt_p1 == CNT_W'(1))
            state_nxt = S_DONE;
        else if (state == S_DONE && out_ready)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // ---- Stage p2: result/flag register (held while out_ready is low) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Result    <= '0;
            Z         <= 1'b0;
            V         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            acc_p1    <= '0;
            mcand_p1  <= '0;
            mplier_p1 <= '0;
            cnt_p1    <= '0;
            mul_hi_p1 <= 1'b0;
        end else if (xfer) begin
            if (is_mul) begin
                acc_p1    <= '0;
                mcand_p1  <= {{WIDTH{1'b0}}, A};
                mplier_p1 <= B;
                cnt_p1    <= CNT_W'(N_STEP);
                mul_hi_p1 <= ALUcontrol[0];
            end else begin
                Result   <= alu_res;
                {Z, N}   <= zn_flags(alu_res);
                V        <= alu_v;
                C        <= alu_c;
            end
        end else if (state == S_MUL) begin
            acc_p1    <= acc_next;
            mcand_p1  <= mcand_p1 << MUL_STEP;
            mplier_p1 <= mplier_p1 >> MUL_STEP;
            cnt_p1    <= cnt_p1 - CNT_W'(1);
            // The last step folds its partial product straight into Result.
            if (cnt_p1 == CNT_W'(1)) begin
                Result <= mul_res;
                {Z, N} <= zn_flags(mul_res);
                V      <= 1'b0;
                C      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH=32, MUL_STEP=2).
module tb_alu_mc;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                           OP_XOR = 4'h4, OP_SLT = 4'h5, OP_SLTU = 4'h6, OP_SLL = 4'h7,
                           OP_SRL = 4'h8, OP_SRA = 4'h9, OP_MUL = 4'hA, OP_MULHU = 4'hB;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Result;
    logic [3:0]  ALUcontrol;
    logic        Z, V, N, C, busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(32), .MUL_STEP(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUcontrol(ALUcontrol), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Z(Z), .V(V), .N(N), .C(C),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        ALUcontrol = o;
        A          = a;
        B          = b;
        in_valid   = 1'b1;
    endtask

    // Accept one MUL/MULHU op, scramble the inputs, and wait (bounded) for out_valid.
    task automatic run_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int cycles, output int bad_busy);
        drive(o, a, b);
        tick;
        in_valid = 1'b0;
        A = 32'hDEADBEEF;
        B = 32'h0BADF00D;
        ALUcontrol = OP_ADD;
        cycles = 0;
        bad_busy = 0;
        while (!out_valid && cycles < 100) begin
            if (!busy || in_ready) bad_busy++;
            tick;
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ALUcontrol = '0;
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (Result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", Result); end
        n_checks++; if ({Z, V, N, C} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {Z, V, N, C}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_addsub;
        logic [3:0]  ops  [5] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_SUB};
        logic [31:0] av   [5] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        logic [31:0] bv   [5] = '{32'h1, 32'h5, 32'h1, 32'h1, 32'h1};
        logic [31:0] exp_r[5] = '{32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [3:0]  exp_f[5] = '{4'b0110, 4'b1001, 4'b1001, 4'b0010, 4'b0101}; // Z V N C
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], av[i], bv[i]);
            tick;
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addsub_valid[%0d] got %b want 1", i, out_valid); end
            n_checks++; if (Result !== exp_r[i]) begin n_fail++; $display("FAIL addsub_result[%0d] got %h want %h", i, Result, exp_r[i]); end
            n_checks++; if ({Z, V, N, C} !== exp_f[i]) begin n_fail++; $display("FAIL addsub_flags[%0d] got %b want %b", i, {Z, V, N, C}, exp_f[i]); end
        end
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addsub_drain got %b want 0", out_valid); end
    endtask

    task automatic test_logic;
        logic [3:0]  ops  [12] = '{OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SRA,
                                   OP_SLL, OP_SRL, OP_SRA, OP_SLL, 4'hC, 4'hF};
        logic [31:0] av   [12] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFFFFF,
                                   32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h80000000,
                                   32'h40000000, 32'h12345678, 32'h5, 32'hFFFFFFFF};
        logic [31:0] bv   [12] = '{32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'h1,
                                   32'h1, 32'd31, 32'h25, 32'h4,
                                   32'h21, 32'h20, 32'h3, 32'hFFFFFFFF};
        logic [31:0] exp_r[12] = '{32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'h1,
                                   32'h0, 32'hFFFFFFFF, 32'h20, 32'h08000000,
                                   32'h20000000, 32'h12345678, 32'h0, 32'h0};
        logic [3:0]  exp_f;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], av[i], bv[i]);
            tick;
            exp_f = {(exp_r[i] == 32'h0), 1'b0, exp_r[i][31], 1'b0};
            n_checks++; if (Result !== exp_r[i]) begin n_fail++; $display("FAIL logic_result[%0d] got %h want %h", i, Result, exp_r[i]); end
            n_checks++; if ({Z, V, N, C} !== exp_f) begin n_fail++; $display("FAIL logic_flags[%0d] got %b want %b", i, {Z, V, N, C}, exp_f); end
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_mul;
        logic [3:0]  ops  [6] = '{OP_MUL, OP_MULHU, OP_MUL, OP_MULHU, OP_MUL, OP_MULHU};
        logic [31:0] av   [6] = '{32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678};
        logic [31:0] bv   [6] = '{32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10, 32'h10};
        logic [31:0] exp_r[6] = '{32'h0, 32'h1, 32'h1, 32'hFFFFFFFE, 32'h23456780, 32'h1};
        logic [3:0]  exp_f;
        int cycles, bad;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_mul(ops[i], av[i], bv[i], cycles, bad);
            exp_f = {(exp_r[i] == 32'h0), 1'b0, exp_r[i][31], 1'b0};
            n_checks++; if (cycles !== 16) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d want 16", i, cycles); end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mul_busy_inready[%0d] got %0d bad cycles want 0", i, bad); end
            n_checks++; if (Result !== exp_r[i]) begin n_fail++; $display("FAIL mul_result[%0d] got %h want %h", i, Result, exp_r[i]); end
            n_checks++; if ({Z, V, N, C} !== exp_f) begin n_fail++; $display("FAIL mul_flags[%0d] got %b want %b", i, {Z, V, N, C}, exp_f); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_done[%0d] got %b want 0", i, busy); end
        end
        tick;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(OP_ADD, 32'd3, 32'd4);
        tick;
        drive(OP_AND, 32'hF0, 32'h3C);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            n_checks++; if (Result !== 32'd7) begin n_fail++; $display("FAIL bp_hold[%0d] got %h want 7", i, Result); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            tick;
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        tick;
        in_valid = 1'b0;
        n_checks++; if (Result !== 32'h30 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next got %h/%b want 30/1", Result, out_valid); end
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_r;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(OP_ADD, 32'(i * 3), 32'd100);
            tick;
            exp_r = 32'(i * 3 + 100);
            n_checks++; if (out_valid !== 1'b1 || Result !== exp_r) begin n_fail++; $display("FAIL stream[%0d] got %h/%b want %h/1", i, Result, out_valid, exp_r); end
        end
        in_valid = 1'b0;
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra got %b want 0", out_valid); end
    endtask

    task automatic test_reset_abort;
        int stray;
        out_ready = 1'b1;
        drive(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (Result !== 32'h0) begin n_fail++; $display("FAIL abort_result got %h want 0", Result); end
        tick;
        tick;
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL abort_stray got %0d cycles want 0", stray); end
        drive(OP_ADD, 32'd1, 32'd1);
        tick;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || Result !== 32'd2) begin n_fail++; $display("FAIL abort_recover got %h/%b want 2/1", Result, out_valid); end
        tick;
    endtask

    initial begin
        test_reset;
        test_addsub;
        test_logic;
        test_mul;
        test_backpressure;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Width-generic; adds XOR, set-less-than, shifts and an iterative multiplier.
- Uses a valid/ready handshake on input and output, so the pipeline can stall on multi-cycle ops.
- Sits in the EX stage between the operand muxes and the EX/MEM register. Produces Result plus Z/V/N/C flags.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- MUL_STEP, 2, multiplier bits retired per cycle (1, 2 or 4; WIDTH divisible by MUL_STEP).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an op this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; shift ops use B[log2(WIDTH)-1:0] as shamt.
- ALUcontrol  in  4  opcode (see Behaviour).
- out_valid  out  1  Result/flags valid.
- out_ready  in  1  consumer accepts result.
- Result  out  WIDTH  registered result.
- Z  out  1  Result == 0.
- V  out  1  signed overflow (ADD/SUB only, else 0).
- N  out  1  Result[WIDTH-1].
- C  out  1  carry out (ADD/SUB only, else 0).
- busy  out  1  multiplier iterating.

Behaviour:
- Opcodes:
  - 0000 ADD; 0001 SUB (A + ~B + 1); 0010 AND; 0011 OR. Low three codes are bit-compatible with the existing 3-bit encoding.
  - 0100 XOR.
  - 0101 SLT (signed, Result = {0..,lt}); 0110 SLTU.
  - 0111 SLL; 1000 SRL; 1001 SRA.
  - 1010 MUL (low WIDTH bits of unsigned A*B); 1011 MULHU (high WIDTH bits).
  - 1100-1111 reserved: Result = 0, all flags 0 except Z=1, single-cycle.
- Flags:
  - C = carry out of the WIDTH-bit adder; for SUB, C=1 means no borrow.
  - V = ~(A[MSB]^B[MSB]^sub) & (A[MSB]^sum[MSB]).
  - Z and N are computed from the final Result for every op, including MUL/MULHU.
- Reset (rst=0, asynchronous): state=IDLE; out_valid=0, busy=0, Result=0, Z=0, V=0, N=0, C=0; internal accumulator and counter cleared.
- FSM states: IDLE, MUL, DONE.
  - IDLE:
    - in_valid & op single-cycle -> latch result/flags, go to DONE.
    - in_valid & op MUL/MULHU -> load multiplicand, multiplier, 2*WIDTH accumulator=0, count=WIDTH/MUL_STEP; go to MUL.
  - MUL: each cycle add (multiplier[MUL_STEP-1:0] * multiplicand shifted) into the accumulator, shift the multiplier right by MUL_STEP, decrement count. When count reaches 1, register the selected half plus flags and go to DONE.
  - DONE: out_valid=1; Result/flags held stable until out_ready.
    - out_ready & in_valid -> accept the next op in the same cycle, same rules as IDLE (back-to-back).
    - out_ready & ~in_valid -> IDLE.
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - An op transfers when in_valid & in_ready.
  - A, B and ALUcontrol are sampled only on transfer; changes at other times are ignored.
  - in_valid may drop without transfer (no obligation).
- Latency, accept to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL/MULHU: WIDTH/MUL_STEP cycles (32/2 → 16).
  - Throughput: 1 op/cycle for single-cycle ops when out_ready stays high.
- busy = (state==MUL). in_ready=0 throughout MUL.
- Width rules:
  - Shift amount is masked to log2(WIDTH) bits; shamt=0 passes A unchanged.
  - SRA replicates A[MSB].
- Reset mid-MUL aborts the op: no out_valid and no partial result visible.
- out_valid never asserts without a transferred op; exactly one result per accepted op.

Test Plan:
- ADD/SUB flags, WIDTH=32, out_ready=1:
  - ADD A=7FFFFFFF B=00000001 -> next cycle Result=80000000, V=1, N=1, C=0, Z=0.
  - SUB A=5 B=5 -> Result=0, Z=1, C=1, V=0.
- Logic/compare/shift:
  - SLT A=FFFFFFFF B=1 -> Result=1; SLTU with same operands -> Result=0.
  - SRA A=80000000 shamt=31 -> Result=FFFFFFFF.
  - SLL A=1 B=0x25 (shamt 5) -> Result=00000020.
- MUL, MUL_STEP=2:
  - MUL A=0001_0000 B=0001_0000 -> busy for 16 cycles; out_valid 16 cycles after accept; Result=0, Z=1.
  - MULHU with the same operands -> Result=00000001.
  - in_ready=0 throughout.
- Back-pressure: accept ADD 3+4, hold out_ready=0 for 5 cycles -> Result=7 held stable, in_ready=0. Raise out_ready with in_valid high (AND F0&3C) -> same-cycle transfer; next cycle Result=30.
- Streaming: 8 consecutive single-cycle ops with in_valid=out_ready=1 -> 8 results on 8 consecutive cycles, in order, no bubbles.
- Reset abort: assert rst low on the 5th cycle of MUL -> out_valid, busy and Result go to 0 immediately. After release, ADD 1+1 -> Result=2 with correct 1-cycle latency.
